eth_frame_gen: RTL

Parametrised Ethernet/IPv4/ICMP echo-request frame generator with a 64-bit AXI-Stream master output that honours `tready` backpressure. It is the next-generation stimulus source for `ethernet_controller` benches and on-board loopback tests. Each frame carries:
- a sequence number;
- a runtime-selectable payload length;
- IPv4 header and ICMP checksums computed in hardware.

Frames are emitted in bursts of configurable count with a programmable inter-frame gap.

---
 rtl/eth_pkg.sv | 15 +
 rtl/ones_comp_sum64.sv | 27 ++
 rtl/eth_frame_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared constants, FSM state type and tkeep helper for the Ethernet/IPv4/ICMP frame generator.
package eth_pkg;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_ICMP = 8'd1;
  localparam logic [7:0]  IP_TTL        = 8'd64;
  localparam logic [7:0]  ICMP_ECHO_REQ = 8'd8;
  localparam int          HDR_LEN       = 42;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_FOLD, S_SEND, S_GAP} state_t;

  // Byte enables for the final beat given (frame length % 8).
  function automatic logic [7:0] tkeep_from_rem(input logic [2:0] rem);
    return (rem == 3'd0) ? 8'hFF : 8'((9'd1 << rem) - 9'd1);
  endfunction
endpackage

// File: rtl/ones_comp_sum64.sv
// Registered one's-complement accumulator: four 16-bit words per cycle into 32 bits,
// with a 16-bit end-around-carry fold of the running sum.
module ones_comp_sum64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] init,
  input  logic [63:0] data,
  output logic [15:0] fold
);
  logic [31:0] acc;
  logic [31:0] add4;
  logic [16:0] f1, f2;

  always_comb begin
    add4 = 32'(data[15:0]) + 32'(data[31:16]) + 32'(data[47:32]) + 32'(data[63:48]);
    f1   = 17'(acc[15:0]) + 17'(acc[31:16]);
    f2   = 17'(f1[15:0]) + 17'(f1[16]);
    fold = f2[15:0];
  end

  // clr restarts the sum from init in the same cycle the first words are added
  always_ff @(posedge clk)
    if (rst)     acc <= '0;
    else if (en) acc <= (clr ? init : acc) + add4;
endmodule

// File: rtl/eth_frame_gen.sv
// Ethernet/IPv4/ICMP echo-request burst generator with 64-bit AXI-Stream output.
// Optional ETH_FRAME_GEN_ERR_INJECT_EN adds i_err_every to corrupt every Nth ICMP checksum.
module eth_frame_gen
  import eth_pkg::*;
#(
  parameter logic [47:0] DST_MAC     = 48'h211abcdef112,
  parameter logic [47:0] SRC_MAC     = 48'h0a0b0c0d0e0f,
  parameter logic [31:0] SRC_IP      = 32'hC0000101,
  parameter logic [31:0] DST_IP      = 32'hC0000186,
  parameter logic [15:0] ICMP_ID     = 16'h0000,
  parameter int          MAX_PAYLOAD = 1472,
  parameter int          IFG_CYCLES  = 12
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [15:0] i_frames,
  input  logic [10:0] i_payload_len,
`ifdef ETH_FRAME_GEN_ERR_INJECT_EN
  input  logic [7:0]  i_err_every,
`endif
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_frame_cnt,
  output logic        o_tx_axis_tvalid,
  output logic [63:0] o_tx_axis_tdata,
  output logic        o_tx_axis_tlast,
  output logic [7:0]  o_tx_axis_tkeep,
  input  logic        i_tx_axis_tready
);
  localparam logic [31:0] IP_CONST = 32'h4500 + 32'({IP_TTL, IP_PROTO_ICMP}) +
                                     32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0]) +
                                     32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);

  state_t      state;
  logic [15:0] seq, frames, gap_cnt, ip_ck, icmp_ck, ip_len;
  logic [10:0] plen, len_clamp;
  logic [11:0] flen;
  logic [7:0]  chunk, chunk_last, bidx, beat_last;
  logic        stop_pend, accept, burst_end, err_hit;
  logic [15:0] ip_fold, icmp_fold;
  logic [31:0] icmp_init;
  logic [63:0] pay_words;
  logic [7:0][7:0] pay_b, beat_b;
  logic [7:0]  hdr [64];

  assign len_clamp  = (i_payload_len > 11'(MAX_PAYLOAD)) ? 11'(MAX_PAYLOAD) : i_payload_len;
  assign flen       = 12'(plen) + 12'(HDR_LEN);
  assign ip_len     = 16'(plen) + 16'd28;
  assign chunk_last = (plen == 11'd0) ? 8'd0 : 8'(((12'(plen) + 12'd7) >> 3) - 12'd1);
  assign beat_last  = 8'(((flen + 12'd7) >> 3) - 12'd1);
  assign accept     = (state == S_IDLE) && i_start && !i_stop;
  assign burst_end  = stop_pend || i_stop || ((frames != 16'd0) && (o_frame_cnt == frames));
  assign icmp_init  = 32'({ICMP_ECHO_REQ, 8'h00}) + 32'(ICMP_ID) + 32'(seq);

  // Payload bytes of the current CALC chunk; bytes past L read as zero, which pads an odd tail.
  for (genvar j = 0; j < 8; j++) begin : g_pay
    logic [10:0] k;
    assign k        = {chunk, 3'(j)};
    assign pay_b[j] = (k < plen) ? seq[7:0] + k[7:0] : 8'h00;
  end
  for (genvar w = 0; w < 4; w++) begin : g_words
    assign pay_words[16*w +: 16] = {pay_b[2*w], pay_b[2*w+1]};
  end

  ones_comp_sum64 u_ip_sum (
    .clk(i_clk), .rst(i_reset), .en(state == S_CALC && chunk == 8'd0), .clr(1'b1),
    .init(IP_CONST), .data({ip_len, seq, 32'h0}), .fold(ip_fold)
  );
  ones_comp_sum64 u_icmp_sum (
    .clk(i_clk), .rst(i_reset), .en(state == S_CALC), .clr(chunk == 8'd0),
    .init(icmp_init), .data(pay_words), .fold(icmp_fold)
  );

  always_comb begin
    for (int i = 0; i < 64; i++) hdr[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      hdr[i]     = DST_MAC[8*(5-i) +: 8];
      hdr[6 + i] = SRC_MAC[8*(5-i) +: 8];
    end
    hdr[12] = ETH_TYPE_IPV4[15:8];
    hdr[13] = ETH_TYPE_IPV4[7:0];
    hdr[14] = 8'h45;
    hdr[16] = ip_len[15:8];
    hdr[17] = ip_len[7:0];
    hdr[18] = seq[15:8];
    hdr[19] = seq[7:0];
    hdr[22] = IP_TTL;
    hdr[23] = IP_PROTO_ICMP;
    hdr[24] = ip_ck[15:8];
    hdr[25] = ip_ck[7:0];
    for (int i = 0; i < 4; i++) begin
      hdr[26 + i] = SRC_IP[8*(3-i) +: 8];
      hdr[30 + i] = DST_IP[8*(3-i) +: 8];
    end
    hdr[34] = ICMP_ECHO_REQ;
    hdr[36] = icmp_ck[15:8];
    hdr[37] = icmp_ck[7:0];
    hdr[38] = ICMP_ID[15:8];
    hdr[39] = ICMP_ID[7:0];
    hdr[40] = seq[15:8];
    hdr[41] = seq[7:0];
  end

  // Frame byte n lands in lane n%8 of beat n/8.
  for (genvar j = 0; j < 8; j++) begin : g_lane
    logic [11:0] n;
    assign n         = {1'b0, bidx, 3'(j)};
    assign beat_b[j] = (n < 12'(HDR_LEN)) ? hdr[n[5:0]] :
                       (n < flen)         ? seq[7:0] + 8'(n - 12'(HDR_LEN)) : 8'h00;
  end

`ifdef ETH_FRAME_GEN_ERR_INJECT_EN
  logic [7:0] err_cnt;
  assign err_hit = (i_err_every != 8'd0) && (err_cnt == i_err_every - 8'd1);
  always_ff @(posedge i_clk)
    if (i_reset || accept)    err_cnt <= 8'd0;
    else if (state == S_FOLD) err_cnt <= err_hit ? 8'd0 : err_cnt + 8'd1;
`else
  assign err_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state            <= S_IDLE;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_frame_cnt      <= '0;
      o_tx_axis_tvalid <= 1'b0;
      o_tx_axis_tdata  <= '0;
      o_tx_axis_tlast  <= 1'b0;
      o_tx_axis_tkeep  <= '0;
      seq              <= '0;
      frames           <= '0;
      plen             <= '0;
      chunk            <= '0;
      bidx             <= '0;
      gap_cnt          <= '0;
      ip_ck            <= '0;
      icmp_ck          <= '0;
      stop_pend        <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_stop && state != S_IDLE) stop_pend <= 1'b1;
      case (state)
        S_IDLE: if (accept) begin
          state       <= S_CALC;
          o_busy      <= 1'b1;
          seq         <= '0;
          frames      <= i_frames;
          o_frame_cnt <= '0;
          plen        <= len_clamp;
          chunk       <= '0;
          stop_pend   <= 1'b0;
        end
        S_CALC: if (chunk == chunk_last) state <= S_FOLD;
                else chunk <= chunk + 8'd1;
        S_FOLD: begin
          ip_ck   <= ~ip_fold;
          icmp_ck <= ~icmp_fold ^ {15'd0, err_hit};
          bidx    <= '0;
          state   <= S_SEND;
        end
        S_SEND: if (!o_tx_axis_tvalid || i_tx_axis_tready) begin
          if (o_tx_axis_tvalid && o_tx_axis_tlast) begin
            o_tx_axis_tvalid <= 1'b0;
            o_tx_axis_tlast  <= 1'b0;
            o_frame_cnt      <= o_frame_cnt + 16'd1;
            seq              <= seq + 16'd1;
            gap_cnt          <= '0;
            state            <= S_GAP;
          end else begin
            o_tx_axis_tvalid <= 1'b1;
            o_tx_axis_tdata  <= beat_b;
            o_tx_axis_tlast  <= (bidx == beat_last);
            o_tx_axis_tkeep  <= (bidx == beat_last) ? tkeep_from_rem(flen[2:0]) : 8'hFF;
            bidx             <= bidx + 8'd1;
          end
        end
        S_GAP: if (gap_cnt == 16'(IFG_CYCLES - 1)) begin
          if (burst_end) begin
            state     <= S_IDLE;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            stop_pend <= 1'b0;
          end else begin
            state <= S_CALC;
            plen  <= len_clamp;
            chunk <= '0;
          end
        end else gap_cnt <= gap_cnt + 16'd1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
